// File: rtl/decoder_rr_arbiter.sv
// Round-robin owner selection for a shared 3-to-8 decoder, with a per-grant hold limit
// that forces a one-cycle gap and hands the resource on so no requester starves.
module decoder_rr_arbiter #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   output logic [2:0] sel,
   output logic       sel_en,
   output logic [7:0] gnt,
   output logic       preempt
);

   localparam int HW = $clog2(MAX_HOLD + 1);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t          state_q, state_d;
   logic [2:0]      ptr_q, ptr_d;
   logic [HW-1:0]   hcnt_q, hcnt_d;
   logic [2:0]      sel_q, sel_d;
   logic            sel_en_q, sel_en_d;
   logic [7:0]      gnt_q, gnt_d;
   logic            preempt_q, preempt_d;

   logic            found;
   logic [2:0]      win;
   logic [2:0]      idx;

   // First requester at or above ptr, wrapping 7 -> 0.
   always_comb begin
      found = 1'b0;
      win   = ptr_q;
      idx   = ptr_q;
      for (int i = 0; i < 8; i++) begin
         idx = ptr_q + 3'(i);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      hcnt_d    = hcnt_q;
      sel_d     = sel_q;
      sel_en_d  = sel_en_q;
      gnt_d     = gnt_q;
      preempt_d = 1'b0;
      case (state_q)
         GRANT: begin
            // Release takes priority over the hold limit, so preempt stays low then.
            if (!req[sel_q] || (hcnt_q == HW'(MAX_HOLD))) begin
               sel_en_d  = 1'b0;
               gnt_d     = 8'h00;
               ptr_d     = sel_q + 3'd1;
               state_d   = GAP;
               preempt_d = req[sel_q];
            end else begin
               hcnt_d = hcnt_q + HW'(1);
            end
         end
         default: begin
            if (found) begin
               sel_d    = win;
               sel_en_d = 1'b1;
               gnt_d    = 8'h01 << win;
               hcnt_d   = HW'(1);
               state_d  = GRANT;
            end else begin
               sel_en_d = 1'b0;
               gnt_d    = 8'h00;
               state_d  = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= 3'd0;
         hcnt_q    <= '0;
         sel_q     <= 3'd0;
         sel_en_q  <= 1'b0;
         gnt_q     <= 8'h00;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         hcnt_q    <= hcnt_d;
         sel_q     <= sel_d;
         sel_en_q  <= sel_en_d;
         gnt_q     <= gnt_d;
         preempt_q <= preempt_d;
      end
   end

   assign sel     = sel_q;
   assign sel_en  = sel_en_q;
   assign gnt     = gnt_q;
   assign preempt = preempt_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter with a cycle-level reference model feeding a scoreboard.
module tb_decoder_rr_arbiter;

   localparam int MH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req;
   logic [2:0] sel;
   logic       sel_en;
   logic [7:0] gnt;
   logic       preempt;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [2:0] sel;
      logic       en;
      logic [7:0] gnt;
      logic       pre;
   } exp_t;

   exp_t q[$];

   // reference model state: 0 idle, 1 grant, 2 gap
   int         m_state;
   int         m_ptr;
   int         m_hcnt;
   logic [2:0] m_sel;
   logic       m_en;
   logic [7:0] m_gnt;
   logic       m_pre;

   decoder_rr_arbiter #(.MAX_HOLD(MH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .sel     (sel),
      .sel_en  (sel_en),
      .gnt     (gnt),
      .preempt (preempt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_ptr = 0; m_hcnt = 0;
      m_sel = 3'd0; m_en = 1'b0; m_gnt = 8'h00; m_pre = 1'b0;
   endtask

   task automatic model_step(input logic [7:0] r);
      int w;
      m_pre = 1'b0;
      if (m_state == 1) begin
         if (r[m_sel] == 1'b0 || m_hcnt == MH) begin
            m_pre   = (r[m_sel] == 1'b1);
            m_en    = 1'b0;
            m_gnt   = 8'h00;
            m_ptr   = (int'(m_sel) + 1) % 8;
            m_state = 2;
         end else begin
            m_hcnt = m_hcnt + 1;
         end
      end else if (r != 8'h00) begin
         w = m_ptr;
         while (r[w] == 1'b0) w = (w + 1) % 8;
         m_sel   = 3'(w);
         m_en    = 1'b1;
         m_gnt   = 8'h00;
         m_gnt[w] = 1'b1;
         m_hcnt  = 1;
         m_state = 1;
      end else begin
         m_en    = 1'b0;
         m_gnt   = 8'h00;
         m_state = 0;
      end
   endtask

   // One clock: drive req, model the edge, then compare at the falling edge.
   task automatic cyc(input logic [7:0] r);
      exp_t e;
      logic [7:0] dec;
      req = r;
      @(posedge clk);
      model_step(r);
      q.push_back({m_sel, m_en, m_gnt, m_pre});
      @(negedge clk);
      e = q.pop_front();
      chk("sel", {5'd0, sel}, {5'd0, e.sel});
      chk("sel_en", {7'd0, sel_en}, {7'd0, e.en});
      chk("gnt", gnt, e.gnt);
      chk("preempt", {7'd0, preempt}, {7'd0, e.pre});
      dec = 8'h00;
      if (sel_en) dec[sel] = 1'b1;
      chk("gnt_vs_decoder", gnt, dec);
   endtask

   initial begin
      logic [2:0] own;
      rst_n = 1'b0;
      req   = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt", gnt, 8'h00);
      chk("rst_sel", {5'd0, sel}, 8'h00);
      chk("rst_sel_en", {7'd0, sel_en}, 8'h00);
      chk("rst_preempt", {7'd0, preempt}, 8'h00);
      rst_n = 1'b1;

      // idle with no requests
      repeat (10) cyc(8'h00);
      chk("idle_gnt", gnt, 8'h00);

      // round-robin 0,2,0,2 with one dead cycle between owners
      for (int k = 0; k < 4; k++) begin
         own = (k % 2 == 1) ? 3'd2 : 3'd0;
         cyc(8'h05);
         chk("rr_first", gnt, 8'h01 << own);
         cyc(8'h05);
         cyc(8'h05);
         chk("rr_third", gnt, 8'h01 << own);
         cyc(8'h05 & ~(8'h01 << own));
         chk("rr_gap", gnt, 8'h00);
         chk("rr_gap_pre", {7'd0, preempt}, 8'h00);
      end
      cyc(8'h00);

      // wrap-around: owner 7 releases, next goes to 0
      cyc(8'h80);
      chk("wrap_own7", gnt, 8'h80);
      cyc(8'h81);
      cyc(8'h01);
      chk("wrap_gap", gnt, 8'h00);
      cyc(8'h81);
      chk("wrap_to0", gnt, 8'h01);
      cyc(8'h00);
      cyc(8'h00);

      // preemption of a lone requester, then re-grant to it
      cyc(8'h08);
      chk("pre_hold1", gnt, 8'h08);
      cyc(8'h08);
      cyc(8'h08);
      cyc(8'h08);
      chk("pre_hold4", gnt, 8'h08);
      cyc(8'h08);
      chk("pre_gap_gnt", gnt, 8'h00);
      chk("pre_gap_flag", {7'd0, preempt}, 8'h01);
      cyc(8'h08);
      chk("pre_regrant3", gnt, 8'h08);
      chk("pre_flag_clr", {7'd0, preempt}, 8'h00);

      // preemption with a competitor pending moves to 4
      cyc(8'h18);
      cyc(8'h18);
      cyc(8'h18);
      cyc(8'h18);
      chk("pre2_flag", {7'd0, preempt}, 8'h01);
      cyc(8'h18);
      chk("pre2_to4", gnt, 8'h10);
      cyc(8'h00);
      cyc(8'h00);

      // release on the same edge the limit is reached counts as release
      cyc(8'h02);
      chk("sim_own1", gnt, 8'h02);
      cyc(8'h02);
      cyc(8'h02);
      cyc(8'h02);
      cyc(8'h00);
      chk("sim_gap_gnt", gnt, 8'h00);
      chk("sim_no_pre", {7'd0, preempt}, 8'h00);
      cyc(8'h00);

      // asynchronous reset in the middle of a grant to 5
      cyc(8'h20);
      chk("mid_own5", gnt, 8'h20);
      cyc(8'h20);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_gnt", gnt, 8'h00);
      chk("arst_sel", {5'd0, sel}, 8'h00);
      chk("arst_sel_en", {7'd0, sel_en}, 8'h00);
      model_reset();
      req = 8'h21;
      @(negedge clk);
      rst_n = 1'b1;
      cyc(8'h21);
      chk("arst_to0", gnt, 8'h01);
      cyc(8'h21);
      cyc(8'h00);
      cyc(8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
